ex_stage_md: RTL and testbench
==============================

Name: ex_stage_md

Overview:
- Parametrised execute stage for the 5-stage RV32 pipeline.
- Contains operand forwarding, ALU, branch-target adder, and an iterative M-extension multiply/divide unit.
- Ends in a registered EX/MEM boundary.
- Stalls the front of the pipeline while a multi-cycle M op is in flight.

Parameters:
- XLEN, 32, datapath width; the iteration count of the M unit equals XLEN.
- FWD_SRCS, 3, forwarding mux inputs: 0 = register file, 1 = WB data, 2 = MEM ALU result. Input 3 is tied to 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  instruction present in EX
- flush  in  1  kill the instruction in EX, including an M op in flight
- hold_in  in  1  downstream (MEM) stall; freeze the output register
- ALUop_EX  in  2  main-decoder ALU class
- FUNCT3_EX  in  3  funct3
- FUNCT7_EX  in  7  funct7
- ALUSrc_EX  in  1  1 = immediate as operand B
- IMM_EX  in  XLEN  immediate
- PC_EX  in  XLEN  instruction PC
- REG_DATA1_EX  in  XLEN  rs1 value from register file
- REG_DATA2_EX  in  XLEN  rs2 value from register file
- forwardA  in  2  operand A select
- forwardB  in  2  operand B select
- ALU_DATA_WB  in  XLEN  WB forwarding source
- ALU_OUT_MEM  in  XLEN  MEM forwarding source
- stall_out  out  1  hold IF/ID/EX
- valid_out  out  1  EX/MEM valid
- ALU_OUT  out  XLEN  registered result
- ZERO  out  1  registered zero flag
- PC_BRANCH  out  XLEN  registered PC_EX + IMM_EX
- STORE_DATA  out  XLEN  registered forwarded rs2 value

Behaviour:
- Reset: all outputs 0, M-unit FSM in IDLE, internal operand registers cleared.
- The reset and clock names, polarity and synchronicity are fixed as stated above.
- Forwarding: operand A = mux(forwardA); operand B = mux(forwardB). STORE_DATA takes the forwarded B before the ALUSrc mux.
- M op detection: ALUop_EX == 2'b10 and FUNCT7_EX == 7'b0000001; funct3 selects the op.
- Non-M ops:
  - Result is registered on the next edge: latency 1, ZERO = (result == 0).
  - stall_out stays 0.
- M-unit FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when valid_in && M op && !flush. On this edge, capture forwarded operands and funct3, and load the counter with XLEN.
  - stall_out is asserted combinationally in that IDLE cycle, and throughout BUSY and DONE.
  - BUSY: one shift-add or restoring-divide step per cycle; the counter decrements. At counter == 1, go to DONE.
  - DONE: drive the result into EX/MEM, deassert stall_out, return to IDLE.
  - Total latency is XLEN + 2 edges from entry to valid_out.
- M op results:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operand signedness respectively.
  - Signed ops use magnitude iteration plus a final sign fix-up.
- Divide by zero: quotient = all ones; remainder = dividend. No trap.
- Signed overflow (DIV of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1); remainder = 0.
- While BUSY or in the stall cycle, EX/MEM receives a bubble (valid_out = 0).
- flush in any state: FSM returns to IDLE next edge, stall_out drops the same cycle, valid_out = 0 next edge.
- hold_in:
  - The EX/MEM register holds its value.
  - The FSM keeps iterating but waits in DONE until hold_in is 0.
  - stall_out stays 1 while waiting.
- Reset mid-operation: abort immediately; no result is produced.
- valid_in = 0: EX/MEM valid_out = 0; data outputs may change.

Optional Feature:
- Macro EX_FAST_MUL_EN.
- When defined: MUL/MULH/MULHSU/MULHU are single-cycle combinational (2·XLEN product) with latency 1 and no stall; divide/remainder stay iterative.
- When undefined: all M ops are iterative as above.

Decomposition:
- Package ex_md_pkg:
  - ALUop encodings
  - M funct7 constant
  - funct3 codes for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
  - FSM state enum
  - ALU control code constants
- One sub-module, muldiv_iter: holds the FSM, counter, shift registers and sign fix-up. Handshake is start/busy/done/abort.
- ALU and ALU-control logic stay inline or reuse the existing units.

Test Plan:
- ADD with forwardA = 2 (ALU_OUT_MEM = 5), REG_DATA2 = 7 -> next edge ALU_OUT = 12, ZERO = 0, stall_out never 1.
- BEQ-style SUB with 9, 9, IMM = 16, PC = 0x100 -> ZERO = 1, PC_BRANCH = 0x110.
- MUL 0xFFFFFFFF × 3 (XLEN = 32) -> stall_out high 33 cycles; valid_out with ALU_OUT = 0xFFFFFFFD at edge 34. MULHU of the same operands -> 0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. DIVU 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 7.
- Start DIV, assert flush at cycle 10 -> stall_out 0 that cycle, valid_out 0 next edge; a following ADD 1 + 1 -> 2 with latency 1.
- Hold_in asserted when DONE is reached on a DIVU 100 / 7, held 3 cycles -> stall_out stays 1; result 14 is presented once hold_in drops. With EX_FAST_MUL_EN: MUL 6 × 7 -> 42 at latency 1, no stall.

Source files
------------

// File: rtl/ex_md_pkg.sv
// Shared encodings for the EX stage: ALU classes, funct codes, ALU control codes and M-unit states.
package ex_md_pkg;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit: shift-add multiply / restoring divide on magnitudes, sign fixed at the end.
// Handshake: i_start (sampled in IDLE) launches, o_busy while iterating, o_done holds the result until !i_hold, i_abort kills.
module muldiv_iter
    import ex_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_hold,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output md_state_t       o_state
);
    localparam int CW = $clog2(XLEN) + 1;

    md_state_t       r_state, w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi, r_lo, r_opb;
    logic [2:0]      r_f3;
    logic            r_neg_a, r_neg_b, r_div0;

    logic            w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic [XLEN:0]   w_add, w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quot, w_rem;

    always_comb begin
        w_sgn_a = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                  (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
        w_sgn_b = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
        w_neg_a = w_sgn_a && i_op_a[XLEN-1];
        w_neg_b = w_sgn_b && i_op_b[XLEN-1];
        w_mag_a = w_neg_a ? -i_op_a : i_op_a;
        w_mag_b = w_neg_b ? -i_op_b : i_op_b;
    end

    // r_lo is the multiplier / dividend-then-quotient; r_hi the partial product / remainder.
    always_comb begin
        w_add   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opb}) : {1'b0, r_hi};
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_opb});
        w_diff  = w_shift[XLEN-1:0] - r_opb;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_state_nx = MD_BUSY;
            MD_BUSY: if (r_cnt == CW'(1)) w_state_nx = MD_DONE;
            MD_DONE: if (!i_hold) w_state_nx = MD_IDLE;
            default: w_state_nx = MD_IDLE;
        endcase
        if (i_abort) w_state_nx = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_f3    <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == MD_IDLE && i_start && !i_abort) begin
                r_cnt   <= CW'(XLEN);
                r_f3    <= i_funct3;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_div0  <= (i_op_b == '0);
                r_hi    <= '0;
                r_lo    <= w_mag_a;
                r_opb   <= w_mag_b;
            end else if (r_state == MD_BUSY) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_f3[2]) begin
                    r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_ge};
                end else begin
                    r_hi <= w_add[XLEN:1];
                    r_lo <= {w_add[0], r_lo[XLEN-1:1]};
                end
            end
        end
    end

    always_comb begin
        w_prod   = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quot   = r_div0 ? '1 : ((r_neg_a ^ r_neg_b) ? -r_lo : r_lo);
        w_rem    = r_neg_a ? -r_hi : r_hi;
        case (r_f3)
            F3_MUL:                        o_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               o_result = w_quot;
            default:                       o_result = w_rem;
        endcase
    end

    assign o_busy  = (r_state == MD_BUSY);
    assign o_done  = (r_state == MD_DONE);
    assign o_state = r_state;

endmodule

// File: rtl/ex_stage_md.sv
// EX stage: forwarding, ALU, branch adder, iterative M unit, registered EX/MEM boundary.
// Build option EX_FAST_MUL_EN makes the MUL family single-cycle; divides stay iterative.
module ex_stage_md
    import ex_md_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            flush,
    input  logic            hold_in,
    input  logic [1:0]      ALUop_EX,
    input  logic [2:0]      FUNCT3_EX,
    input  logic [6:0]      FUNCT7_EX,
    input  logic            ALUSrc_EX,
    input  logic [XLEN-1:0] IMM_EX,
    input  logic [XLEN-1:0] PC_EX,
    input  logic [XLEN-1:0] REG_DATA1_EX,
    input  logic [XLEN-1:0] REG_DATA2_EX,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] ALU_DATA_WB,
    input  logic [XLEN-1:0] ALU_OUT_MEM,
    output logic            stall_out,
    output logic            valid_out,
    output logic [XLEN-1:0] ALU_OUT,
    output logic            ZERO,
    output logic [XLEN-1:0] PC_BRANCH,
    output logic [XLEN-1:0] STORE_DATA
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_src_a [4];
    logic [XLEN-1:0] w_src_b [4];
    logic [XLEN-1:0] w_op_a, w_op_b_fwd, w_op_b, w_alu_result, w_pc_branch, w_md_result;
    logic [3:0]      w_alu_ctrl;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_m, w_m_iter, w_start, w_md_busy, w_md_done;
    md_state_t       w_md_state;

    logic            r_valid, r_zero;
    logic [XLEN-1:0] r_alu_out, r_pc_branch, r_store;

    // Mux inputs at or beyond FWD_SRCS read as zero.
    always_comb begin
        w_src_a[0] = REG_DATA1_EX;
        w_src_a[1] = ALU_DATA_WB;
        w_src_a[2] = ALU_OUT_MEM;
        w_src_a[3] = '0;
        w_src_b[0] = REG_DATA2_EX;
        w_src_b[1] = ALU_DATA_WB;
        w_src_b[2] = ALU_OUT_MEM;
        w_src_b[3] = '0;
        w_op_a     = (int'(forwardA) < FWD_SRCS) ? w_src_a[forwardA] : '0;
        w_op_b_fwd = (int'(forwardB) < FWD_SRCS) ? w_src_b[forwardB] : '0;
        w_op_b     = ALUSrc_EX ? IMM_EX : w_op_b_fwd;
        w_shamt    = w_op_b[SHW-1:0];
        w_pc_branch = PC_EX + IMM_EX;
    end

    assign w_is_m = (ALUop_EX == ALUOP_RTYPE) && (FUNCT7_EX == F7_MULDIV);
`ifdef EX_FAST_MUL_EN
    assign w_m_iter = w_is_m && FUNCT3_EX[2];
`else
    assign w_m_iter = w_is_m;
`endif

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (ALUop_EX)
            ALUOP_ADD:    w_alu_ctrl = ALU_ADD;
            ALUOP_BRANCH: w_alu_ctrl = ALU_SUB;
            default: begin
                case (FUNCT3_EX)
                    3'b000:  w_alu_ctrl = (ALUop_EX == ALUOP_RTYPE && FUNCT7_EX == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_alu_ctrl = ALU_SLL;
                    3'b010:  w_alu_ctrl = ALU_SLT;
                    3'b011:  w_alu_ctrl = ALU_SLTU;
                    3'b100:  w_alu_ctrl = ALU_XOR;
                    3'b101:  w_alu_ctrl = (FUNCT7_EX == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  w_alu_ctrl = ALU_OR;
                    default: w_alu_ctrl = ALU_AND;
                endcase
`ifdef EX_FAST_MUL_EN
                if (w_is_m) w_alu_ctrl = ALU_MUL + {2'b00, FUNCT3_EX[1:0]};
`endif
            end
        endcase
    end

`ifdef EX_FAST_MUL_EN
    logic signed [XLEN:0]     w_fm_a, w_fm_b;
    logic signed [2*XLEN+1:0] w_fm_prod;
    always_comb begin
        w_fm_a    = {(FUNCT3_EX == F3_MULH || FUNCT3_EX == F3_MULHSU) && w_op_a[XLEN-1], w_op_a};
        w_fm_b    = {(FUNCT3_EX == F3_MULH) && w_op_b[XLEN-1], w_op_b};
        w_fm_prod = w_fm_a * w_fm_b;
    end
`endif

    always_comb begin
        w_alu_result = '0;
        case (w_alu_ctrl)
            ALU_ADD:  w_alu_result = w_op_a + w_op_b;
            ALU_SUB:  w_alu_result = w_op_a - w_op_b;
            ALU_SLL:  w_alu_result = w_op_a << w_shamt;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
            ALU_XOR:  w_alu_result = w_op_a ^ w_op_b;
            ALU_SRL:  w_alu_result = w_op_a >> w_shamt;
            ALU_SRA:  w_alu_result = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_OR:   w_alu_result = w_op_a | w_op_b;
            ALU_AND:  w_alu_result = w_op_a & w_op_b;
`ifdef EX_FAST_MUL_EN
            ALU_MUL:  w_alu_result = w_fm_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: w_alu_result = w_fm_prod[2*XLEN-1:XLEN];
`endif
            default:  w_alu_result = '0;
        endcase
    end

    assign w_start = valid_in && w_m_iter && !flush && (w_md_state == MD_IDLE);

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_abort  (flush),
        .i_hold   (hold_in),
        .i_funct3 (FUNCT3_EX),
        .i_op_a   (w_op_a),
        .i_op_b   (w_op_b_fwd),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result),
        .o_state  (w_md_state)
    );

    assign stall_out = !flush && (w_start || w_md_busy || (w_md_done && hold_in));

    // EX/MEM: M result on the DONE edge, bubbles while the M unit owns the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_zero      <= 1'b0;
            r_alu_out   <= '0;
            r_pc_branch <= '0;
            r_store     <= '0;
        end else if (!hold_in) begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_md_done) begin
                r_valid     <= 1'b1;
                r_alu_out   <= w_md_result;
                r_zero      <= (w_md_result == '0);
                r_pc_branch <= w_pc_branch;
                r_store     <= w_op_b_fwd;
            end else if (w_start || w_md_busy) begin
                r_valid <= 1'b0;
            end else begin
                r_valid     <= valid_in;
                r_alu_out   <= w_alu_result;
                r_zero      <= (w_alu_result == '0);
                r_pc_branch <= w_pc_branch;
                r_store     <= w_op_b_fwd;
            end
        end
    end

    assign valid_out  = r_valid;
    assign ALU_OUT    = r_alu_out;
    assign ZERO       = r_zero;
    assign PC_BRANCH  = r_pc_branch;
    assign STORE_DATA = r_store;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU path, forwarding, M ops with latency/stall counting, flush, hold, reset abort.
module tb_ex_stage_md;

    logic        clk = 1'b0;
    logic        reset, valid_in, flush, hold_in, ALUSrc_EX;
    logic [1:0]  ALUop_EX, forwardA, forwardB;
    logic [2:0]  FUNCT3_EX;
    logic [6:0]  FUNCT7_EX;
    logic [31:0] IMM_EX, PC_EX, REG_DATA1_EX, REG_DATA2_EX, ALU_DATA_WB, ALU_OUT_MEM;
    logic        stall_out, valid_out, ZERO;
    logic [31:0] ALU_OUT, PC_BRANCH, STORE_DATA;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

`ifdef EX_FAST_MUL_EN
    localparam int MUL_STALLS = 0;
    localparam int MUL_LAT    = 1;
`else
    localparam int MUL_STALLS = 33;
    localparam int MUL_LAT    = 34;
`endif
    localparam int DIV_STALLS = 33;
    localparam int DIV_LAT    = 34;

    ex_stage_md dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush), .hold_in(hold_in),
        .ALUop_EX(ALUop_EX), .FUNCT3_EX(FUNCT3_EX), .FUNCT7_EX(FUNCT7_EX), .ALUSrc_EX(ALUSrc_EX),
        .IMM_EX(IMM_EX), .PC_EX(PC_EX), .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX),
        .forwardA(forwardA), .forwardB(forwardB), .ALU_DATA_WB(ALU_DATA_WB), .ALU_OUT_MEM(ALU_OUT_MEM),
        .stall_out(stall_out), .valid_out(valid_out), .ALU_OUT(ALU_OUT), .ZERO(ZERO),
        .PC_BRANCH(PC_BRANCH), .STORE_DATA(STORE_DATA)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic alusrc, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [1:0] fa, input logic [1:0] fb);
        ALUop_EX = aluop; FUNCT3_EX = f3; FUNCT7_EX = f7; ALUSrc_EX = alusrc;
        IMM_EX = imm; PC_EX = pc; REG_DATA1_EX = r1; REG_DATA2_EX = r2;
        forwardA = fa; forwardB = fb; valid_in = 1'b1;
    endtask

    // Issue an M op, count stall cycles and edges until valid_out, then compare the result.
    task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_stalls, input int exp_lat);
        int   stalls = 0;
        int   edges  = 0;
        logic seen   = 1'b0;
        logic [31:0] want;
        set_op(2'b10, f3, 7'h01, 1'b0, 32'h0, 32'h0, a, b, 2'd0, 2'd0);
        exp_q.push_back(exp);
        while (!seen && edges < 100) begin
            #1;
            if (stall_out) stalls++;
            tick();
            edges++;
            if (valid_out) seen = 1'b1;
        end
        valid_in = 1'b0;
        want = exp_q.pop_front();
        check({tag, "_lat"}, edges, exp_lat);
        check({tag, "_stalls"}, stalls, exp_stalls);
        check({tag, "_valid"}, valid_out, 1'b1);
        check({tag, "_res"}, ALU_OUT, want);
        check({tag, "_zero"}, ZERO, want == 32'h0);
        tick();
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; hold_in = 1'b0;
        set_op(2'b00, 3'd0, 7'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0);
        valid_in = 1'b0; ALU_DATA_WB = 32'd0; ALU_OUT_MEM = 32'd0;
        tick(); tick();
        check("rst_valid", valid_out, 1'b0);
        check("rst_alu", ALU_OUT, 32'h0);
        check("rst_zero", ZERO, 1'b0);
        check("rst_pcb", PC_BRANCH, 32'h0);
        check("rst_store", STORE_DATA, 32'h0);
        check("rst_stall", stall_out, 1'b0);
        reset = 1'b0;
        tick();

        // ADD with operand A forwarded from MEM
        ALU_OUT_MEM = 32'd5;
        set_op(2'b10, 3'd0, 7'd0, 1'b0, 32'd0, 32'd0, 32'd99, 32'd7, 2'd2, 2'd0);
        #1 check("add_stall", stall_out, 1'b0);
        tick();
        check("add_valid", valid_out, 1'b1);
        check("add_res", ALU_OUT, 32'd12);
        check("add_zero", ZERO, 1'b0);
        check("add_store", STORE_DATA, 32'd7);

        // Branch compare and target
        set_op(2'b01, 3'd0, 7'd0, 1'b0, 32'd16, 32'h100, 32'd9, 32'd9, 2'd0, 2'd0);
        tick();
        check("beq_zero", ZERO, 1'b1);
        check("beq_res", ALU_OUT, 32'h0);
        check("beq_pcb", PC_BRANCH, 32'h110);

        // ADDI with rs2 forwarded from WB reaching STORE_DATA ahead of the ALUSrc mux
        ALU_DATA_WB = 32'h55;
        set_op(2'b11, 3'd0, 7'd0, 1'b1, 32'hFFFF_FFFD, 32'd0, 32'd10, 32'd1, 2'd0, 2'd1);
        tick();
        check("addi_res", ALU_OUT, 32'd7);
        check("addi_store", STORE_DATA, 32'h55);

        set_op(2'b10, 3'd5, 7'h20, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 32'd4, 2'd0, 2'd0);
        tick();
        check("sra_res", ALU_OUT, 32'hF800_0000);

        valid_in = 1'b0;
        tick();
        check("idle_valid", valid_out, 1'b0);

        run_m("mul",    3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, MUL_STALLS, MUL_LAT);
        run_m("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, MUL_STALLS, MUL_LAT);
        run_m("mulh",   3'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, MUL_STALLS, MUL_LAT);
        run_m("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, MUL_STALLS, MUL_LAT);
        run_m("mul67",  3'd0, 32'd6, 32'd7, 32'd42, MUL_STALLS, MUL_LAT);
        run_m("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_STALLS, DIV_LAT);
        run_m("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, DIV_STALLS, DIV_LAT);
        run_m("divu_z",  3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, DIV_STALLS, DIV_LAT);
        run_m("remu_z",  3'd7, 32'd7, 32'd0, 32'd7, DIV_STALLS, DIV_LAT);
        run_m("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_STALLS, DIV_LAT);
        run_m("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_STALLS, DIV_LAT);
        run_m("div_z",   3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, DIV_STALLS, DIV_LAT);
        run_m("rem_z",   3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, DIV_STALLS, DIV_LAT);

        // Flush a divide in flight, then a plain ADD
        set_op(2'b10, 3'd4, 7'h01, 1'b0, 32'd0, 32'd0, 32'd100, 32'd7, 2'd0, 2'd0);
        for (int i = 0; i < 10; i++) tick();
        check("fl_busy_stall", stall_out, 1'b1);
        flush = 1'b1;
        #1 check("fl_stall", stall_out, 1'b0);
        tick();
        check("fl_valid", valid_out, 1'b0);
        flush = 1'b0;
        set_op(2'b10, 3'd0, 7'd0, 1'b0, 32'd0, 32'd0, 32'd1, 32'd1, 2'd0, 2'd0);
        #1 check("fl_add_stall", stall_out, 1'b0);
        tick();
        check("fl_add_valid", valid_out, 1'b1);
        check("fl_add_res", ALU_OUT, 32'd2);
        valid_in = 1'b0;
        tick();

        // Hold asserted on reaching DONE for a DIVU 100 / 7
        set_op(2'b10, 3'd5, 7'h01, 1'b0, 32'd0, 32'd0, 32'd100, 32'd7, 2'd0, 2'd0);
        for (int i = 0; i < 33; i++) tick();
        hold_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", stall_out, 1'b1);
            tick();
            check("hold_valid", valid_out, 1'b0);
        end
        hold_in = 1'b0;
        #1 check("hold_rel_stall", stall_out, 1'b0);
        tick();
        check("hold_res_valid", valid_out, 1'b1);
        check("hold_res", ALU_OUT, 32'd14);
        valid_in = 1'b0;
        tick();

        // Reset in the middle of a divide aborts it
        set_op(2'b10, 3'd4, 7'h01, 1'b0, 32'd0, 32'd0, 32'd100, 32'd7, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        valid_in = 1'b0;
        tick();
        reset = 1'b0;
        #1 check("rmid_stall", stall_out, 1'b0);
        check("rmid_valid", valid_out, 1'b0);
        check("rmid_alu", ALU_OUT, 32'h0);
        for (int i = 0; i < 40; i++) tick();
        check("rmid_noresult", valid_out, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
